pwd_detect: RTL and testbench

Parametrised serial password detector: accepts one qualified bit per cycle and compares each received group of `WIDTH` bits against a runtime-loadable key. It supports a sliding-window mode (every bit position checked) and a framed-attempt mode with failure counting and timed lockout. It sits behind the serial input front end and drives the unlock/alarm logic.

---
 rtl/pwd_pkg.sv | 17 +
 rtl/pwd_shift.sv | 49 ++++
 rtl/pwd_detect.sv | 113 +++++++++++
 tb/tb_pwd_detect.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pwd_pkg.sv
// Shared types and helpers for the serial password detector.
package pwd_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    LOCKED  = 1'b1
  } pwd_state_e;

  // Bits needed to hold values 0..value-1, never less than one.
  function automatic int pwd_clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/pwd_shift.sv
// Serial-in shift register with bit counter and full-width key compare.
// The hit/equal outputs describe the bit being accepted on this edge.
module pwd_shift import pwd_pkg::*; #(
  parameter int WIDTH   = 4,
  parameter int OVERLAP = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             shift_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] key_i,
  output logic             hit_o,
  output logic             equal_o
);

  localparam int CW = pwd_clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Sliding mode saturates the count at WIDTH; framed mode wraps after each attempt.
  always_comb begin
    data_d  = (data_q << 1) | WIDTH'(bit_i);
    equal_o = (data_d == key_i);
    hit_o   = 1'b0;
    cnt_d   = cnt_q;
    if (OVERLAP != 0) begin
      hit_o = shift_i && (cnt_q >= LAST);
      if (shift_i && (cnt_q != FULL)) cnt_d = cnt_q + CW'(1);
    end else begin
      hit_o = shift_i && (cnt_q == LAST);
      if (shift_i) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (shift_i) begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/pwd_detect.sv
// Serial password detector: sliding-window or framed attempts with
// failure counting and a timed lockout.
module pwd_detect import pwd_pkg::*; #(
  parameter int             WIDTH       = 4,
  parameter logic [WIDTH-1:0] PATTERN   = 4'b1001,
  parameter int             OVERLAP     = 0,
  parameter int             MAX_FAIL    = 3,
  parameter int             LOCK_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             clr,
  input  logic             key_load,
  input  logic [WIDTH-1:0] key_in,
  output logic             out,
  output logic             fail,
  output logic             locked
);

  localparam int FW = pwd_clog2(MAX_FAIL + 1);
  localparam int TW = pwd_clog2(LOCK_CYCLES + 1);

  pwd_state_e       state_q, state_d;
  logic [FW-1:0]    failCnt_q, failCnt_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic             out_q, out_d;
  logic             fail_q, fail_d;

  logic collecting, accept, expire, shiftClear, hit, equal;

  assign collecting = (state_q == COLLECT);
  assign accept     = collecting && in_valid && !clr && !key_load;
  assign expire     = (state_q == LOCKED) && (timer_q == TW'(1));
  assign shiftClear = (collecting && (clr || key_load)) || expire;

  pwd_shift #(
    .WIDTH   (WIDTH),
    .OVERLAP (OVERLAP)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .clear_i (shiftClear),
    .shift_i (accept),
    .bit_i   (in),
    .key_i   (key_q),
    .hit_o   (hit),
    .equal_o (equal)
  );

  // Failures only exist in framed mode, so sliding mode never reaches LOCKED.
  always_comb begin
    state_d   = state_q;
    failCnt_d = failCnt_q;
    timer_d   = timer_q;
    key_d     = key_q;
    out_d     = 1'b0;
    fail_d    = 1'b0;
    case (state_q)
      COLLECT: begin
        if (key_load) key_d = key_in;
        if (hit) begin
          if (equal) begin
            out_d     = 1'b1;
            failCnt_d = '0;
          end else if (OVERLAP == 0) begin
            fail_d    = 1'b1;
            failCnt_d = failCnt_q + FW'(1);
            if (failCnt_q == FW'(MAX_FAIL - 1)) begin
              state_d = LOCKED;
              timer_d = TW'(LOCK_CYCLES);
            end
          end
        end
      end
      LOCKED: begin
        if (expire) begin
          state_d   = COLLECT;
          failCnt_d = '0;
          timer_d   = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      failCnt_q <= '0;
      timer_q   <= '0;
      key_q     <= PATTERN;
      out_q     <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      failCnt_q <= failCnt_d;
      timer_q   <= timer_d;
      key_q     <= key_d;
      out_q     <= out_d;
      fail_q    <= fail_d;
    end
  end

  assign out    = out_q;
  assign fail   = fail_q;
  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_pwd_detect.sv
// Drives a framed and a sliding-window detector from the same inputs and
// compares both against a queue-based reference model.
module tb_pwd_detect;

  localparam int         W       = 4;
  localparam logic [3:0] PAT     = 4'b1001;
  localparam int         MAXF    = 3;
  localparam int         LOCKCYC = 16;

  logic clk = 1'b0;
  logic rst, inValid, inBit, clr, keyLoad;
  logic [W-1:0] keyIn;
  logic outF, failF, lockedF, outO, failO, lockedO;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic       frameQ[$];
  logic       histQ[$];
  logic [3:0] keyF, keyO;
  int         fails, lockLeft;
  logic       expOutF, expFailF, expOutO;

  always #5 clk = ~clk;

  pwd_detect #(.WIDTH(W), .PATTERN(PAT), .OVERLAP(0), .MAX_FAIL(MAXF), .LOCK_CYCLES(LOCKCYC)) dutF (
    .clk(clk), .rst(rst), .in_valid(inValid), .in(inBit), .clr(clr),
    .key_load(keyLoad), .key_in(keyIn), .out(outF), .fail(failF), .locked(lockedF)
  );

  pwd_detect #(.WIDTH(W), .PATTERN(PAT), .OVERLAP(1), .MAX_FAIL(MAXF), .LOCK_CYCLES(LOCKCYC)) dutO (
    .clk(clk), .rst(rst), .in_valid(inValid), .in(inBit), .clr(clr),
    .key_load(keyLoad), .key_in(keyIn), .out(outO), .fail(failO), .locked(lockedO)
  );

  function automatic logic [3:0] packBits(input logic q[$]);
    logic [3:0] v;
    v = '0;
    foreach (q[i]) v = {v[2:0], q[i]};
    return v;
  endfunction

  // Applies the rules of one clock edge to the reference model.
  task automatic modelStep(input logic r, input logic v, input logic b,
                           input logic c, input logic kl, input logic [3:0] kv);
    expOutF  = 1'b0;
    expFailF = 1'b0;
    expOutO  = 1'b0;
    if (r) begin
      keyF = PAT;
      keyO = PAT;
      frameQ.delete();
      histQ.delete();
      fails    = 0;
      lockLeft = 0;
    end else begin
      if (c || kl) begin
        if (kl) keyO = kv;
        histQ.delete();
      end else if (v) begin
        histQ.push_back(b);
        if (histQ.size() > W) void'(histQ.pop_front());
        if (histQ.size() == W && packBits(histQ) == keyO) expOutO = 1'b1;
      end
      if (lockLeft > 0) begin
        lockLeft--;
        if (lockLeft == 0) begin
          fails = 0;
          frameQ.delete();
        end
      end else if (c || kl) begin
        if (kl) keyF = kv;
        frameQ.delete();
      end else if (v) begin
        frameQ.push_back(b);
        if (frameQ.size() == W) begin
          if (packBits(frameQ) == keyF) begin
            expOutF = 1'b1;
            fails   = 0;
          end else begin
            expFailF = 1'b1;
            fails++;
            if (fails == MAXF) lockLeft = LOCKCYC;
          end
          frameQ.delete();
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0b expected=%0b at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic b,
                               input logic c, input logic kl, input logic [3:0] kv);
    rst = r; inValid = v; inBit = b; clr = c; keyLoad = kl; keyIn = kv;
    @(posedge clk);
    modelStep(r, v, b, c, kl, kv);
    #1;
    checkOutput("framed_out", outF, expOutF);
    checkOutput("framed_fail", failF, expFailF);
    checkOutput("framed_locked", lockedF, lockLeft > 0);
    checkOutput("overlap_out", outO, expOutO);
    checkOutput("overlap_fail", failO, 1'b0);
    checkOutput("overlap_locked", lockedO, 1'b0);
  endtask

  task automatic sendBits(input logic [3:0] bits);
    logic [3:0] v;
    v = bits;
    for (int i = W - 1; i >= 0; i--) applyStimulus(1'b0, 1'b1, v[i], 1'b0, 1'b0, 4'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    rst = 1'b1; inValid = 1'b0; inBit = 1'b0; clr = 1'b0; keyLoad = 1'b0; keyIn = '0;
    $display("[TB] start");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);

    // Basic match
    sendBits(4'b1001);
    idle(2);

    // Three failures lock the framed detector; bits and key loads during lockout are ignored
    sendBits(4'b1111);
    sendBits(4'b1111);
    sendBits(4'b1111);
    sendBits(4'b1001);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0110);
    sendBits(4'b1001);
    idle(7);
    sendBits(4'b1001);
    idle(1);

    // A success between failures clears the failure count
    sendBits(4'b1111);
    sendBits(4'b0000);
    sendBits(4'b1001);
    sendBits(4'b1110);
    sendBits(4'b0111);
    sendBits(4'b1001);

    // Overlapping stream 1001001
    sendBits(4'b1001);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, (i == 2), 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0);

    // Key change in the middle of a partial attempt
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0110);
    sendBits(4'b0110);
    sendBits(4'b1001);

    // Reset mid-lockout restores the default key
    sendBits(4'b0000);
    sendBits(4'b0000);
    idle(3);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    sendBits(4'b1001);

    // Reset mid-attempt
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    sendBits(4'b1001);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic r, v, b, c, kl;
      logic [3:0] kv;
      r  = ($urandom_range(0, 199) == 0);
      v  = ($urandom_range(0, 3) != 0);
      b  = $urandom_range(0, 1);
      c  = ($urandom_range(0, 24) == 0);
      kl = ($urandom_range(0, 39) == 0);
      kv = ($urandom_range(0, 1) == 0) ? PAT : 4'($urandom_range(0, 15));
      applyStimulus(r, v, b, c, kl, kv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
